axi_decerr_responder: RTL and testbench
=======================================

Name: axi_decerr_responder

Overview:
- Default AXI4 slave on the SoC crossbar; terminates every transaction whose address matches none of the peripheral rules (DRAM, GPIO, Ethernet, SPI, Timer, UART, PLIC, CLINT, ROM, Debug).
- Answers with a DECERR response: the responder end of the crossbar's address decode.
- Also records the last offending address and keeps a saturating error count for debug.

Parameters:
- IdWidth, 6, AXI ID width on the slave side (4 + clog2 of 4 crossbar masters).
- AddrWidth, 64, address width.
- DataWidth, 64, data width.
- RespData, 64'hDEAD_BEEF_DEAD_BEEF, constant driven on r_data_o.
- CntWidth, 32, width of the error counter.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  synchronous active-low reset.
- aw_valid_i  in  1  write-address valid.
- aw_ready_o  out  1  write-address ready.
- aw_id_i  in  IdWidth  write ID.
- aw_addr_i  in  AddrWidth  write address.
- w_valid_i  in  1  write-data valid.
- w_ready_o  out  1  write-data ready.
- w_last_i  in  1  last write beat.
- b_valid_o  out  1  write-response valid.
- b_ready_i  in  1  write-response ready.
- b_id_o  out  IdWidth  echoed write ID.
- b_resp_o  out  2  write response, always 2'b11.
- ar_valid_i  in  1  read-address valid.
- ar_ready_o  out  1  read-address ready.
- ar_id_i  in  IdWidth  read ID.
- ar_addr_i  in  AddrWidth  read address.
- ar_len_i  in  8  burst length minus 1.
- r_valid_o  out  1  read-data valid.
- r_ready_i  in  1  read-data ready.
- r_id_o  out  IdWidth  echoed read ID.
- r_data_o  out  DataWidth  RespData.
- r_resp_o  out  2  read response, always 2'b11.
- r_last_o  out  1  last read beat.
- err_addr_o  out  AddrWidth  address of the most recent errored request.
- err_cnt_o  out  CntWidth  saturating count of errored requests.

Behaviour:
- Reset: one clock `clk_i`; reset `rst_ni` is synchronous and active-low. While rst_ni=0, all ready and valid outputs are 0. Registered outputs reset to 0: b_id_o, r_id_o, err_addr_o, err_cnt_o. The write FSM resets to W_IDLE and the read FSM to R_IDLE.
- Reset mid-operation: both FSMs return to idle; any in-flight response is dropped.
- Channel independence: the write and read paths run as independent FSMs with no shared stall. Each path has one outstanding transaction.
- Write FSM:
  - W_IDLE: aw_ready_o=1. On AW handshake, latch aw_id_i and go to W_DATA.
  - W_DATA: w_ready_o=1. Swallow beats; aw_len is ignored. On a handshake with w_last_i=1, go to W_RESP.
  - W_RESP: b_valid_o=1, b_resp_o=2'b11. On b_ready_i, go to W_IDLE.
  - W beats presented before AW are held off (w_ready_o=0 outside W_DATA).
  - Latency: b_valid_o rises the cycle after the w_last handshake. A single-beat write therefore completes in at least 3 cycles.
- Read FSM:
  - R_IDLE: ar_ready_o=1. On AR handshake, latch ar_id_i and load beat counter = ar_len_i; go to R_DATA.
  - R_DATA: r_valid_o=1, r_resp_o=2'b11, r_data_o=RespData, r_last_o=(cnt==0). Each handshake decrements cnt. The handshake with r_last_o=1 returns to R_IDLE.
  - Latency: first r_valid_o is the cycle after the AR handshake.
  - ar_len_i=255 yields exactly 256 beats; the counter is 8 bits and never wraps below 0.
- Holding: r_valid_o and b_valid_o stay high, with stable payload, until accepted (AXI rule). Back-pressure on R or B stalls only its own path.
- Error capture:
  - Every AW or AR handshake updates err_addr_o with that address and increments err_cnt_o.
  - Simultaneous AW and AR handshakes: err_cnt_o += 2 and err_addr_o takes the AW address.
  - The counter saturates at all-ones, including for +2 at max-1.

Decomposition:
- Shared package (alongside ariane_soc): AXI response encodings RESP_OKAY=2'b00 and RESP_DECERR=2'b11, plus the IdWidthSlave constant, which sets the IdWidth default.
- FSM state enums stay local.
- Optional sub-module axi_decerr_rd_chan for the read FSM and beat counter. The write path and capture logic remain top-level.

Test Plan:
- AW(id=5, addr=0x5000_0000), then one W beat with last → B(id=5, resp=11) one cycle after the W handshake; err_addr_o=0x5000_0000, err_cnt_o=1.
- AR(id=0x2A, len=3) with r_ready_i held 1 → 4 R beats, all id=0x2A, resp=11, data=RespData; r_last_o only on the 4th; R_IDLE afterwards.
- AR len=255 with r_ready_i toggled every other cycle → exactly 256 beats, payload stable while stalled, single r_last_o.
- AW and AR handshake in the same cycle with err_cnt_o preset near max (0xFFFF_FFFE) → err_cnt_o=0xFFFF_FFFF, err_addr_o=AW address; B and R both complete.
- W beats driven before AW → w_ready_o=0 until AW is accepted; no B generated early.
- rst_ni pulled low mid-burst after 2 of 8 R beats → next cycle r_valid_o=0, ar_ready_o=0, err_cnt_o=0. After release, a fresh AR(len=0) returns 1 beat with r_last_o=1.

Source files
------------

// File: rtl/axi_decerr_responder_pkg.sv
// Shared AXI constants for the default-slave (decode error) responder.
package axi_decerr_responder_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  // 4 ID bits from each master plus clog2(4) crossbar master-index bits.
  localparam int unsigned IdWidthSlave = 6;

endpackage

// File: rtl/axi_decerr_rd_chan.sv
// Read path of the decode-error responder: accepts one AR and then
// returns ar_len+1 DECERR beats carrying a constant data word.
module axi_decerr_rd_chan
  import axi_decerr_responder_pkg::*;
#(
  parameter int unsigned          IdWidth   = IdWidthSlave,
  parameter int unsigned          DataWidth = 64,
  parameter logic [DataWidth-1:0] RespData  = 64'hDEAD_BEEF_DEAD_BEEF
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 ar_valid_i,
  output logic                 ar_ready_o,
  input  logic [IdWidth-1:0]   ar_id_i,
  input  logic [7:0]           ar_len_i,
  output logic                 r_valid_o,
  input  logic                 r_ready_i,
  output logic [IdWidth-1:0]   r_id_o,
  output logic [DataWidth-1:0] r_data_o,
  output logic [1:0]           r_resp_o,
  output logic                 r_last_o
);

  typedef enum logic {R_IDLE, R_DATA} r_state_e;

  r_state_e   state_q;
  logic [7:0] cnt_q;

  assign r_data_o = RespData;
  assign r_resp_o = RESP_DECERR;

  // NOTE: state and registered outputs use non-blocking assignments so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q    <= R_IDLE;
      ar_ready_o <= 1'b0;
      r_valid_o  <= 1'b0;
      r_last_o   <= 1'b0;
      r_id_o     <= '0;
      cnt_q      <= '0;
    end else begin
      case (state_q)
        R_IDLE: begin
          if (ar_valid_i && ar_ready_o) begin
            state_q    <= R_DATA;
            ar_ready_o <= 1'b0;
            r_valid_o  <= 1'b1;
            r_id_o     <= ar_id_i;
            cnt_q      <= ar_len_i;
            r_last_o   <= (ar_len_i == 8'd0);
          end else begin
            ar_ready_o <= 1'b1;
          end
        end
        R_DATA: begin
          if (r_ready_i) begin
            if (r_last_o) begin
              state_q    <= R_IDLE;
              r_valid_o  <= 1'b0;
              r_last_o   <= 1'b0;
              ar_ready_o <= 1'b1;
            end else begin
              // The counter stops at zero; the last beat never decrements it.
              cnt_q    <= cnt_q - 8'd1;
              r_last_o <= (cnt_q == 8'd1);
            end
          end
        end
        default: state_q <= R_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/axi_decerr_responder.sv
// Default AXI4 slave: answers every unmatched request with DECERR and keeps
// the last offending address plus a saturating error count for debug.
module axi_decerr_responder
  import axi_decerr_responder_pkg::*;
#(
  parameter int unsigned          IdWidth   = IdWidthSlave,
  parameter int unsigned          AddrWidth = 64,
  parameter int unsigned          DataWidth = 64,
  parameter logic [DataWidth-1:0] RespData  = 64'hDEAD_BEEF_DEAD_BEEF,
  parameter int unsigned          CntWidth  = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 aw_valid_i,
  output logic                 aw_ready_o,
  input  logic [IdWidth-1:0]   aw_id_i,
  input  logic [AddrWidth-1:0] aw_addr_i,
  input  logic                 w_valid_i,
  output logic                 w_ready_o,
  input  logic                 w_last_i,
  output logic                 b_valid_o,
  input  logic                 b_ready_i,
  output logic [IdWidth-1:0]   b_id_o,
  output logic [1:0]           b_resp_o,
  input  logic                 ar_valid_i,
  output logic                 ar_ready_o,
  input  logic [IdWidth-1:0]   ar_id_i,
  input  logic [AddrWidth-1:0] ar_addr_i,
  input  logic [7:0]           ar_len_i,
  output logic                 r_valid_o,
  input  logic                 r_ready_i,
  output logic [IdWidth-1:0]   r_id_o,
  output logic [DataWidth-1:0] r_data_o,
  output logic [1:0]           r_resp_o,
  output logic                 r_last_o,
  output logic [AddrWidth-1:0] err_addr_o,
  output logic [CntWidth-1:0]  err_cnt_o
);

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;

  w_state_e w_state_q;

  assign b_resp_o = RESP_DECERR;

  // NOTE: reset is synchronous, so it is only checked inside the clocked
  // branch and never appears in the sensitivity list.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      w_state_q  <= W_IDLE;
      aw_ready_o <= 1'b0;
      w_ready_o  <= 1'b0;
      b_valid_o  <= 1'b0;
      b_id_o     <= '0;
    end else begin
      case (w_state_q)
        W_IDLE: begin
          if (aw_valid_i && aw_ready_o) begin
            w_state_q  <= W_DATA;
            aw_ready_o <= 1'b0;
            w_ready_o  <= 1'b1;
            b_id_o     <= aw_id_i;
          end else begin
            aw_ready_o <= 1'b1;
          end
        end
        W_DATA: begin
          // Burst length is never checked; w_last alone ends the burst.
          if (w_valid_i && w_last_i) begin
            w_state_q <= W_RESP;
            w_ready_o <= 1'b0;
            b_valid_o <= 1'b1;
          end
        end
        W_RESP: begin
          if (b_ready_i) begin
            w_state_q  <= W_IDLE;
            b_valid_o  <= 1'b0;
            aw_ready_o <= 1'b1;
          end
        end
        default: w_state_q <= W_IDLE;
      endcase
    end
  end

  axi_decerr_rd_chan #(
    .IdWidth   (IdWidth),
    .DataWidth (DataWidth),
    .RespData  (RespData)
  ) i_rd_chan (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .ar_valid_i (ar_valid_i),
    .ar_ready_o (ar_ready_o),
    .ar_id_i    (ar_id_i),
    .ar_len_i   (ar_len_i),
    .r_valid_o  (r_valid_o),
    .r_ready_i  (r_ready_i),
    .r_id_o     (r_id_o),
    .r_data_o   (r_data_o),
    .r_resp_o   (r_resp_o),
    .r_last_o   (r_last_o)
  );

  // Error capture: both channels may hand over a request in the same cycle.
  logic              aw_hs, ar_hs;
  logic [1:0]        err_inc;
  logic [CntWidth:0] err_sum;

  assign aw_hs   = aw_valid_i & aw_ready_o;
  assign ar_hs   = ar_valid_i & ar_ready_o;
  assign err_inc = {1'b0, aw_hs} + {1'b0, ar_hs};
  assign err_sum = {1'b0, err_cnt_o} + (CntWidth+1)'(err_inc);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      err_addr_o <= '0;
      err_cnt_o  <= '0;
    end else begin
      if (aw_hs) begin
        err_addr_o <= aw_addr_i;
      end else if (ar_hs) begin
        err_addr_o <= ar_addr_i;
      end
      // A carry out of the sum means the count ran past all-ones.
      err_cnt_o <= err_sum[CntWidth] ? '1 : err_sum[CntWidth-1:0];
    end
  end

endmodule

// File: tb/tb_axi_decerr_responder.sv
// Directed bench for the decode-error responder. The error counter is built
// 4 bits wide so saturation (max-1 -> max, +2) is reachable in a few requests.
module tb_axi_decerr_responder;

  localparam int unsigned IW = 6;
  localparam int unsigned AW = 64;
  localparam int unsigned DW = 64;
  localparam int unsigned CW = 4;
  localparam logic [DW-1:0] RESP_DATA = 64'hDEAD_BEEF_DEAD_BEEF;

  logic          clk_i = 1'b0;
  logic          rst_ni;
  logic          aw_valid_i, aw_ready_o;
  logic [IW-1:0] aw_id_i;
  logic [AW-1:0] aw_addr_i;
  logic          w_valid_i, w_ready_o, w_last_i;
  logic          b_valid_o, b_ready_i;
  logic [IW-1:0] b_id_o;
  logic [1:0]    b_resp_o;
  logic          ar_valid_i, ar_ready_o;
  logic [IW-1:0] ar_id_i;
  logic [AW-1:0] ar_addr_i;
  logic [7:0]    ar_len_i;
  logic          r_valid_o, r_ready_i;
  logic [IW-1:0] r_id_o;
  logic [DW-1:0] r_data_o;
  logic [1:0]    r_resp_o;
  logic          r_last_o;
  logic [AW-1:0] err_addr_o;
  logic [CW-1:0] err_cnt_o;

  int checks = 0;
  int errors = 0;

  axi_decerr_responder #(
    .IdWidth   (IW),
    .AddrWidth (AW),
    .DataWidth (DW),
    .RespData  (RESP_DATA),
    .CntWidth  (CW)
  ) dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .aw_valid_i (aw_valid_i),
    .aw_ready_o (aw_ready_o),
    .aw_id_i    (aw_id_i),
    .aw_addr_i  (aw_addr_i),
    .w_valid_i  (w_valid_i),
    .w_ready_o  (w_ready_o),
    .w_last_i   (w_last_i),
    .b_valid_o  (b_valid_o),
    .b_ready_i  (b_ready_i),
    .b_id_o     (b_id_o),
    .b_resp_o   (b_resp_o),
    .ar_valid_i (ar_valid_i),
    .ar_ready_o (ar_ready_o),
    .ar_id_i    (ar_id_i),
    .ar_addr_i  (ar_addr_i),
    .ar_len_i   (ar_len_i),
    .r_valid_o  (r_valid_o),
    .r_ready_i  (r_ready_i),
    .r_id_o     (r_id_o),
    .r_data_o   (r_data_o),
    .r_resp_o   (r_resp_o),
    .r_last_o   (r_last_o),
    .err_addr_o (err_addr_o),
    .err_cnt_o  (err_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [63:0] observed,
                       input logic [63:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Advance one edge and settle; all checks happen 1 time unit after posedge.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic rd_single(input logic [AW-1:0] addr);
    ar_valid_i = 1'b1; ar_addr_i = addr; ar_len_i = 8'd0; ar_id_i = 6'h01;
    tick();
    ar_valid_i = 1'b0; r_ready_i = 1'b1;
    tick();
    r_ready_i = 1'b0;
  endtask

  // Simultaneous AW+AR, then complete both responses.
  task automatic pair(input logic [AW-1:0] waddr, input logic [AW-1:0] raddr,
                      input logic [CW-1:0] exp_cnt);
    aw_valid_i = 1'b1; aw_addr_i = waddr; aw_id_i = 6'h07;
    ar_valid_i = 1'b1; ar_addr_i = raddr; ar_id_i = 6'h08; ar_len_i = 8'd0;
    tick();
    check("pair_cnt", 64'(err_cnt_o), 64'(exp_cnt));
    check("pair_addr", err_addr_o, waddr);
    aw_valid_i = 1'b0; ar_valid_i = 1'b0;
    w_valid_i = 1'b1; w_last_i = 1'b1; r_ready_i = 1'b1; b_ready_i = 1'b1;
    check("pair_rvalid", 64'(r_valid_o), 64'd1);
    tick();
    w_valid_i = 1'b0;
    check("pair_bvalid", 64'(b_valid_o), 64'd1);
    check("pair_r_done", 64'(r_valid_o), 64'd0);
    tick();
    check("pair_b_done", 64'(b_valid_o), 64'd0);
    check("pair_idle", 64'({aw_ready_o, ar_ready_o}), 64'd3);
    r_ready_i = 1'b0; b_ready_i = 1'b0;
  endtask

  initial begin
    int beats, lasts, cyc;
    bit stable_ok, last_ok;
    logic [DW+IW:0] held;

    rst_ni = 1'b0;
    aw_valid_i = 0; aw_id_i = '0; aw_addr_i = '0;
    w_valid_i = 0; w_last_i = 0; b_ready_i = 0;
    ar_valid_i = 0; ar_id_i = '0; ar_addr_i = '0; ar_len_i = '0; r_ready_i = 0;

    // Reset state
    tick(); tick();
    check("rst_readys", 64'({aw_ready_o, w_ready_o, ar_ready_o}), 64'd0);
    check("rst_valids", 64'({b_valid_o, r_valid_o}), 64'd0);
    check("rst_ids", 64'({b_id_o, r_id_o}), 64'd0);
    check("rst_err_addr", err_addr_o, 64'd0);
    check("rst_err_cnt", 64'(err_cnt_o), 64'd0);
    rst_ni = 1'b1;
    tick();
    check("idle_aw_ready", 64'(aw_ready_o), 64'd1);
    check("idle_ar_ready", 64'(ar_ready_o), 64'd1);

    // W beats before AW are held off
    w_valid_i = 1'b1; w_last_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("early_w_ready", 64'(w_ready_o), 64'd0);
      check("early_b_valid", 64'(b_valid_o), 64'd0);
    end

    // Single-beat write
    aw_valid_i = 1'b1; aw_id_i = 6'd5; aw_addr_i = 64'h5000_0000;
    tick();
    aw_valid_i = 1'b0;
    check("wr_w_ready", 64'(w_ready_o), 64'd1);
    check("wr_aw_ready", 64'(aw_ready_o), 64'd0);
    check("wr_err_addr", err_addr_o, 64'h5000_0000);
    check("wr_err_cnt", 64'(err_cnt_o), 64'd1);
    tick();
    w_valid_i = 1'b0; w_last_i = 1'b0;
    check("wr_b_valid", 64'(b_valid_o), 64'd1);
    check("wr_b_id", 64'(b_id_o), 64'd5);
    check("wr_b_resp", 64'(b_resp_o), 64'd3);
    tick();
    check("wr_b_hold", 64'({b_valid_o, b_id_o}), 64'({1'b1, 6'd5}));
    b_ready_i = 1'b1;
    tick();
    b_ready_i = 1'b0;
    check("wr_b_done", 64'(b_valid_o), 64'd0);
    check("wr_back_idle", 64'(aw_ready_o), 64'd1);

    // 4-beat read, r_ready held high
    ar_valid_i = 1'b1; ar_id_i = 6'h2A; ar_len_i = 8'd3; ar_addr_i = 64'h7000_0000;
    r_ready_i = 1'b1;
    tick();
    ar_valid_i = 1'b0;
    check("rd4_err_cnt", 64'(err_cnt_o), 64'd2);
    check("rd4_err_addr", err_addr_o, 64'h7000_0000);
    for (int i = 0; i < 4; i++) begin
      check("rd4_valid", 64'(r_valid_o), 64'd1);
      check("rd4_id", 64'(r_id_o), 64'h2A);
      check("rd4_resp", 64'(r_resp_o), 64'd3);
      check("rd4_data", r_data_o, RESP_DATA);
      check("rd4_last", 64'(r_last_o), 64'(i == 3));
      tick();
    end
    check("rd4_done", 64'(r_valid_o), 64'd0);
    check("rd4_idle", 64'(ar_ready_o), 64'd1);

    // 256-beat read with r_ready toggling
    r_ready_i = 1'b0;
    ar_valid_i = 1'b1; ar_id_i = 6'h15; ar_len_i = 8'd255; ar_addr_i = 64'h8000_1000;
    tick();
    ar_valid_i = 1'b0;
    beats = 0; lasts = 0; cyc = 0; stable_ok = 1'b1; last_ok = 1'b1;
    while (r_valid_o && cyc < 1000) begin
      r_ready_i = cyc[0];
      held = {r_last_o, r_id_o, r_data_o};
      if (r_ready_i) begin
        beats++;
        if (r_last_o) begin
          lasts++;
          if (beats != 256) last_ok = 1'b0;
        end
      end
      tick();
      if (!r_ready_i && held !== {r_last_o, r_id_o, r_data_o}) stable_ok = 1'b0;
      if (r_valid_o && (r_id_o !== 6'h15 || r_data_o !== RESP_DATA)) stable_ok = 1'b0;
      cyc++;
    end
    r_ready_i = 1'b0;
    check("rd256_timeout", 64'(r_valid_o), 64'd0);
    check("rd256_beats", 64'(beats), 64'd256);
    check("rd256_lasts", 64'(lasts), 64'd1);
    check("rd256_last_pos", 64'(last_ok), 64'd1);
    check("rd256_stable", 64'(stable_ok), 64'd1);
    check("rd256_err_cnt", 64'(err_cnt_o), 64'd3);

    // Raise the count to max-1 (14), then simultaneous AW+AR
    for (int i = 0; i < 11; i++) rd_single(64'h9000_0000 + 64'(i));
    check("pre_sat_cnt", 64'(err_cnt_o), 64'd14);
    check("pre_sat_addr", err_addr_o, 64'h9000_000A);
    pair(64'hA000_0000, 64'hB000_0000, 4'hF);
    pair(64'hA000_0040, 64'hB000_0040, 4'hF);

    // Reset mid-burst after 2 of 8 beats
    ar_valid_i = 1'b1; ar_id_i = 6'h11; ar_len_i = 8'd7; ar_addr_i = 64'hC000_0000;
    r_ready_i = 1'b1;
    tick();
    ar_valid_i = 1'b0;
    tick(); tick();
    check("mid_still_valid", 64'(r_valid_o), 64'd1);
    rst_ni = 1'b0;
    tick();
    check("mid_rst_rvalid", 64'(r_valid_o), 64'd0);
    check("mid_rst_arready", 64'(ar_ready_o), 64'd0);
    check("mid_rst_cnt", 64'(err_cnt_o), 64'd0);
    rst_ni = 1'b1;
    r_ready_i = 1'b0;
    tick();
    check("post_rst_arready", 64'(ar_ready_o), 64'd1);
    check("post_rst_rvalid", 64'(r_valid_o), 64'd0);
    ar_valid_i = 1'b1; ar_id_i = 6'h03; ar_len_i = 8'd0; ar_addr_i = 64'hD000_0000;
    tick();
    ar_valid_i = 1'b0;
    check("post_rst_beat", 64'({r_valid_o, r_last_o}), 64'd3);
    check("post_rst_id", 64'(r_id_o), 64'h03);
    check("post_rst_cnt", 64'(err_cnt_o), 64'd1);
    r_ready_i = 1'b1;
    tick();
    r_ready_i = 1'b0;
    check("post_rst_done", 64'(r_valid_o), 64'd0);
    check("post_rst_idle", 64'(ar_ready_o), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
